vcve2_dmem_arbiter: RTL and testbench

VCVE2_DMEM_ARBITER -- requirements
Module: vcve2_dmem_arbiter

---
 rtl/vcve2_dmem_arbiter.sv | 129 ++++++++++++
 tb/tb_vcve2_dmem_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/vcve2_dmem_arbiter.sv
// Round-robin arbiter sharing one data memory port among NumReq requesters.
// Tracks granted IDs in a FIFO so responses are routed back in order.
module vcve2_dmem_arbiter #(
  parameter int NumReq         = 2,
  parameter int MaxOutstanding = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumReq-1:0]                    req_req_i,
  output logic [NumReq-1:0]                    req_gnt_o,
  output logic [NumReq-1:0]                    req_rvalid_o,
  input  logic [NumReq-1:0]                    req_we_i,
  input  logic [NumReq*4-1:0]                  req_be_i,
  input  logic [NumReq*32-1:0]                 req_addr_i,
  input  logic [NumReq*32-1:0]                 req_wdata_i,
  output logic [NumReq*32-1:0]                 req_rdata_o,
  output logic [NumReq-1:0]                    req_err_o,
  output logic                                 data_req_o,
  output logic                                 data_we_o,
  output logic [3:0]                           data_be_o,
  output logic [31:0]                          data_addr_o,
  output logic [31:0]                          data_wdata_o,
  input  logic                                 data_gnt_i,
  input  logic                                 data_rvalid_i,
  input  logic                                 data_err_i,
  input  logic [31:0]                          data_rdata_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
  output logic                                 resp_orphan_o
);
  localparam int IdxW = $clog2(NumReq);
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding+1);

  logic [IdxW-1:0] rr_q, lock_id_q, sel_idx, head;
  logic            lock_q, orphan_q, sel_valid, full, grant, pop;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic [IdxW-1:0] fifo_q [MaxOutstanding];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding-1)) ? '0 : p + PtrW'(1);
  endfunction

  // A stalled request keeps its selection until granted, so the memory
  // never sees attributes change under an un-acknowledged request.
  always_comb begin
    int idx;
    idx       = 0;
    sel_valid = 1'b0;
    sel_idx   = '0;
    if (lock_q && req_req_i[lock_id_q]) begin
      sel_valid = 1'b1;
      sel_idx   = lock_id_q;
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        idx = (int'(rr_q) + i) % NumReq;
        if (!sel_valid && req_req_i[idx]) begin
          sel_valid = 1'b1;
          sel_idx   = IdxW'(idx);
        end
      end
    end
  end

  assign full       = (cnt_q == CntW'(MaxOutstanding));
  assign data_req_o = sel_valid & ~full & ~rst_i;
  assign grant      = data_req_o & data_gnt_i;
  assign pop        = data_rvalid_i & (cnt_q != '0) & ~rst_i;
  assign head       = fifo_q[rd_ptr_q];

  always_comb begin
    data_we_o    = 1'b0;
    data_be_o    = '0;
    data_addr_o  = '0;
    data_wdata_o = '0;
    if (sel_valid) begin
      data_we_o    = req_we_i[sel_idx];
      data_be_o    = req_be_i[int'(sel_idx)*4 +: 4];
      data_addr_o  = req_addr_i[int'(sel_idx)*32 +: 32];
      data_wdata_o = req_wdata_i[int'(sel_idx)*32 +: 32];
    end
  end

  for (genvar g = 0; g < NumReq; g++) begin : g_req
    assign req_gnt_o[g]             = grant && (sel_idx == IdxW'(g));
    assign req_rvalid_o[g]          = pop && (head == IdxW'(g));
    assign req_err_o[g]             = pop && data_err_i && (head == IdxW'(g));
    assign req_rdata_o[g*32 +: 32]  = data_rdata_i;
  end

  assign outstanding_o = rst_i ? '0 : cnt_q;
  assign resp_orphan_o = orphan_q & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      orphan_q  <= 1'b0;
    end else begin
      if (grant) rr_q <= IdxW'((int'(sel_idx) + 1) % NumReq);

      // While full, data_req_o is low, so the lock neither sets nor clears here.
      if (grant) begin
        lock_q <= 1'b0;
      end else if (data_req_o) begin
        lock_q    <= 1'b1;
        lock_id_q <= sel_idx;
      end else if (lock_q && !req_req_i[lock_id_q]) begin
        lock_q <= 1'b0;
      end

      if (grant) begin
        fifo_q[wr_ptr_q] <= sel_idx;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);

      if (grant && !pop)      cnt_q <= cnt_q + CntW'(1);
      else if (pop && !grant) cnt_q <= cnt_q - CntW'(1);

      if (data_rvalid_i && cnt_q == '0) orphan_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vcve2_dmem_arbiter.sv
// Directed bench for vcve2_dmem_arbiter (NumReq=2, MaxOutstanding=2).
module tb_vcve2_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  we = 2'b10;
  logic [7:0]  be = 8'h3F;
  logic [63:0] addr = {32'h0000_2000, 32'h0000_1000};
  logic [63:0] wdata = {32'hB1B1_B1B1, 32'hA0A0_A0A0};
  logic        gnt = 1'b0, rv = 1'b0, err = 1'b0;
  logic [31:0] rdata = 32'h5555_1234;
  logic [1:0]  req_gnt, req_rvalid, req_err;
  logic [63:0] req_rdata;
  logic        data_req, data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata;
  logic [1:0]  outst;
  logic        orphan;
  int          n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  vcve2_dmem_arbiter #(.NumReq(2), .MaxOutstanding(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_req_i(req), .req_gnt_o(req_gnt), .req_rvalid_o(req_rvalid),
    .req_we_i(we), .req_be_i(be), .req_addr_i(addr), .req_wdata_i(wdata),
    .req_rdata_o(req_rdata), .req_err_o(req_err),
    .data_req_o(data_req), .data_we_o(data_we), .data_be_o(data_be),
    .data_addr_o(data_addr), .data_wdata_o(data_wdata),
    .data_gnt_i(gnt), .data_rvalid_i(rv), .data_err_i(err), .data_rdata_i(rdata),
    .outstanding_o(outst), .resp_orphan_o(orphan)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Inputs change 1ns after the rising edge; checks run 2ns later.
  task automatic cyc(input logic r, input logic [1:0] q, input logic g,
                     input logic v, input logic e);
    @(posedge clk); #1;
    rst = r; req = q; gnt = g; rv = v; err = e;
    #2;
  endtask

  initial begin
    // reset holds outputs quiet even with requests pending
    cyc(1, 2'b11, 1, 0, 0);
    chk("rst_req", data_req, 0);
    chk("rst_gnt", req_gnt, 0);
    chk("rst_outst", outst, 0);
    chk("rst_orphan", orphan, 0);
    cyc(1, 2'b11, 1, 1, 0);
    chk("rst_rvalid", req_rvalid, 0);

    // alternating grants, response one cycle later
    cyc(0, 2'b11, 1, 0, 0);
    chk("alt_g0", req_gnt, 2'b01);
    chk("alt_a0", data_addr, 32'h1000);
    chk("alt_wd0", data_wdata, 32'hA0A0_A0A0);
    cyc(0, 2'b11, 1, 1, 0);
    chk("alt_g1", req_gnt, 2'b10);
    chk("alt_a1", data_addr, 32'h2000);
    chk("alt_rv1", req_rvalid, 2'b01);
    chk("alt_out1", outst, 1);
    cyc(0, 2'b11, 1, 1, 0);
    chk("alt_g2", req_gnt, 2'b01);
    chk("alt_rv2", req_rvalid, 2'b10);
    cyc(0, 2'b11, 1, 1, 0);
    chk("alt_g3", req_gnt, 2'b10);
    chk("alt_rv3", req_rvalid, 2'b01);
    cyc(0, 2'b00, 1, 1, 0);
    chk("alt_idle_req", data_req, 0);
    chk("alt_rv4", req_rvalid, 2'b10);
    chk("alt_out4", outst, 1);
    chk("rdata_bcast", req_rdata, {2{32'h5555_1234}});
    cyc(0, 2'b00, 0, 0, 0);
    chk("alt_drain", outst, 0);

    // lock: req0 stalls, req1 arrives with rr pointing at it
    cyc(0, 2'b01, 1, 0, 0);
    chk("lk_pre_g", req_gnt, 2'b01);
    cyc(0, 2'b00, 0, 1, 0);
    chk("lk_pre_rv", req_rvalid, 2'b01);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 2'b01, 0, 0, 0);
      chk("lk_stall_req", data_req, 1);
      chk("lk_stall_g", req_gnt, 0);
    end
    cyc(0, 2'b11, 0, 0, 0);
    chk("lk_hold_a", data_addr, 32'h1000);
    cyc(0, 2'b11, 1, 0, 0);
    chk("lk_gnt", req_gnt, 2'b01);
    chk("lk_gnt_a", data_addr, 32'h1000);
    cyc(0, 2'b11, 1, 0, 0);
    chk("lk_rr_g", req_gnt, 2'b10);
    chk("lk_rr_we", data_we, 1);
    chk("lk_rr_be", data_be, 4'h3);
    cyc(0, 2'b00, 0, 1, 0);
    chk("lk_out2", outst, 2);
    chk("lk_rv0", req_rvalid, 2'b01);
    cyc(0, 2'b00, 0, 1, 0);
    chk("lk_rv1", req_rvalid, 2'b10);
    cyc(0, 2'b00, 0, 0, 0);
    chk("nosel_addr", data_addr, 0);
    chk("nosel_be", data_be, 0);

    // in-order error routing: grant 1 then 0, error on the second
    cyc(0, 2'b10, 1, 0, 0);
    chk("er_g1", req_gnt, 2'b10);
    cyc(0, 2'b01, 1, 0, 0);
    chk("er_g0", req_gnt, 2'b01);
    cyc(0, 2'b00, 0, 1, 0);
    chk("er_rv1", req_rvalid, 2'b10);
    chk("er_e1", req_err, 2'b00);
    cyc(0, 2'b00, 0, 1, 1);
    chk("er_rv0", req_rvalid, 2'b01);
    chk("er_e0", req_err, 2'b01);
    cyc(0, 2'b00, 0, 0, 0);
    chk("er_drain", outst, 0);

    // FIFO full stalls, no bypass when a pop coincides
    cyc(0, 2'b01, 1, 0, 0);
    chk("fl_g0", req_gnt, 2'b01);
    cyc(0, 2'b01, 1, 0, 0);
    chk("fl_g1", req_gnt, 2'b01);
    chk("fl_out1", outst, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 2'b01, 1, 0, 0);
      chk("fl_stall_req", data_req, 0);
      chk("fl_out2", outst, 2);
    end
    cyc(0, 2'b01, 1, 1, 0);
    chk("fl_nobyp_req", data_req, 0);
    chk("fl_nobyp_g", req_gnt, 0);
    chk("fl_pop_rv", req_rvalid, 2'b01);
    cyc(0, 2'b01, 1, 0, 0);
    chk("fl_resume", req_gnt, 2'b01);
    chk("fl_out_res", outst, 1);
    cyc(0, 2'b00, 0, 1, 0);
    chk("fl_rvA", req_rvalid, 2'b01);
    cyc(0, 2'b00, 0, 1, 0);
    chk("fl_rvB", req_rvalid, 2'b01);
    cyc(0, 2'b00, 0, 0, 0);
    chk("fl_drain", outst, 0);

    // reset with two outstanding, then orphan response
    cyc(0, 2'b11, 1, 0, 0);
    chk("rs_g1", req_gnt, 2'b10);
    cyc(0, 2'b11, 1, 0, 0);
    chk("rs_g0", req_gnt, 2'b01);
    cyc(0, 2'b00, 0, 0, 0);
    chk("rs_out2", outst, 2);
    cyc(1, 2'b11, 1, 0, 0);
    chk("rs_in_req", data_req, 0);
    chk("rs_in_g", req_gnt, 0);
    cyc(0, 2'b11, 0, 0, 0);
    chk("rs_out0", outst, 0);
    chk("rs_rr0", data_addr, 32'h1000);
    chk("rs_req", data_req, 1);
    cyc(0, 2'b00, 0, 1, 0);
    chk("or_rv", req_rvalid, 0);
    chk("or_pre", orphan, 0);
    cyc(0, 2'b00, 0, 0, 0);
    chk("or_set", orphan, 1);
    chk("or_out", outst, 0);
    cyc(0, 2'b00, 0, 0, 0);
    chk("or_hold", orphan, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
